// File: rtl/uart_mem_streamer.sv
// Streams NUM_REGIONS memory regions word by word as bytes over a valid/ready byte sink.
// Optional feature macro UART_MEM_STREAMER_CHECKSUM_EN appends a per-region checksum byte.
module uart_mem_streamer #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int NUM_REGIONS = 2,
    parameter int START_DELAY = 400000,
    parameter int MSB_FIRST   = 0
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic                                              start_i,
    input  logic [NUM_REGIONS*ADDR_W-1:0]                     region_base_i,
    input  logic [NUM_REGIONS*ADDR_W-1:0]                     region_len_i,
    output logic                                              mem_rd_o,
    output logic [ADDR_W-1:0]                                 mem_addr_o,
    input  logic [DATA_W-1:0]                                 mem_rdata_i,
    output logic                                              wvalid_o,
    input  logic                                              wready_i,
    output logic [7:0]                                        wdata_o,
    output logic                                              busy_o,
    output logic                                              done_o,
    output logic [(NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1)-1:0] region_o
);

    localparam int BYTES    = DATA_W / 8;
    localparam int BI_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int RG_W     = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int DLY_W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int DLY_INIT = (START_DELAY > 0) ? START_DELAY - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_FETCH = 3'd2,
        S_LOAD  = 3'd3,
        S_SEND  = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
`ifdef UART_MEM_STREAMER_CHECKSUM_EN
        , S_CSUM = 3'd7
`endif
    } state_t;

    function automatic logic [ADDR_W-1:0] field(input logic [NUM_REGIONS*ADDR_W-1:0] v,
                                                input logic [RG_W-1:0] r);
        return v[int'(r)*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [7:0] first_byte(input logic [DATA_W-1:0] w);
        if (MSB_FIRST != 0) return w[DATA_W-1 -: 8];
        else return w[7:0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
        if (MSB_FIRST != 0) return w << 8;
        else return w >> 8;
    endfunction

    state_t              state_q;
    logic [DLY_W-1:0]    dly_q;
    logic [RG_W-1:0]     region_q;
    logic [ADDR_W-1:0]   word_idx_q;
    logic [BI_W-1:0]     byte_idx_q;
    logic [DATA_W-1:0]   shift_q;
    logic                mem_rd_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                wvalid_q;
    logic [7:0]          wdata_q;
    logic                busy_q;
    logic                done_q;
`ifdef UART_MEM_STREAMER_CHECKSUM_EN
    logic [7:0]          acc_q;
`endif

    logic [ADDR_W-1:0]   cur_base_s;
    logic [ADDR_W-1:0]   cur_len_s;
    logic [RG_W-1:0]     nxt_region_s;
    logic [ADDR_W-1:0]   word_nxt_s;
    logic [DATA_W-1:0]   shifted_s;
    logic                accept_s;

    assign cur_base_s   = field(region_base_i, region_q);
    assign cur_len_s    = field(region_len_i, region_q);
    assign nxt_region_s = region_q + RG_W'(1);
    assign word_nxt_s   = word_idx_q + ADDR_W'(1);
    assign shifted_s    = shift_word(shift_q);
    assign accept_s     = wvalid_q & wready_i;

    // The read strobe is raised on the transition into FETCH so that LOAD sees the returned word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            dly_q      <= '0;
            region_q   <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            wvalid_q   <= 1'b0;
            wdata_q    <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_MEM_STREAMER_CHECKSUM_EN
            acc_q      <= 8'h00;
`endif
        end else begin
            mem_rd_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q    <= S_WAIT;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        region_q   <= '0;
                        word_idx_q <= '0;
                        dly_q      <= DLY_W'(DLY_INIT);
`ifdef UART_MEM_STREAMER_CHECKSUM_EN
                        acc_q      <= 8'h00;
`endif
                    end
                end
                S_WAIT: begin
                    if (dly_q == '0) begin
                        state_q    <= S_FETCH;
                        mem_rd_q   <= (cur_len_s != '0);
                        mem_addr_q <= cur_base_s;
                    end else begin
                        dly_q <= dly_q - DLY_W'(1);
                    end
                end
                S_FETCH: begin
                    if (cur_len_s == '0) begin
`ifdef UART_MEM_STREAMER_CHECKSUM_EN
                        state_q  <= S_CSUM;
                        wvalid_q <= 1'b1;
                        wdata_q  <= 8'h00 - acc_q;
`else
                        state_q  <= S_NEXT;
`endif
                    end else begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    shift_q    <= mem_rdata_i;
                    wdata_q    <= first_byte(mem_rdata_i);
                    wvalid_q   <= 1'b1;
                    byte_idx_q <= '0;
                    state_q    <= S_SEND;
                end
                S_SEND: begin
                    if (accept_s) begin
                        byte_idx_q <= byte_idx_q + BI_W'(1);
`ifdef UART_MEM_STREAMER_CHECKSUM_EN
                        acc_q      <= acc_q + wdata_q;
`endif
                        if (byte_idx_q == BI_W'(BYTES - 1)) begin
                            wvalid_q   <= 1'b0;
                            word_idx_q <= word_nxt_s;
                            if (word_nxt_s == cur_len_s) begin
`ifdef UART_MEM_STREAMER_CHECKSUM_EN
                                state_q  <= S_CSUM;
                                wvalid_q <= 1'b1;
                                wdata_q  <= 8'h00 - (acc_q + wdata_q);
`else
                                state_q  <= S_NEXT;
`endif
                            end else begin
                                state_q    <= S_FETCH;
                                mem_rd_q   <= 1'b1;
                                mem_addr_q <= cur_base_s + word_nxt_s;
                            end
                        end else begin
                            shift_q <= shifted_s;
                            wdata_q <= first_byte(shifted_s);
                        end
                    end
                end
`ifdef UART_MEM_STREAMER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept_s) begin
                        wvalid_q <= 1'b0;
                        state_q  <= S_NEXT;
                    end
                end
`endif
                S_NEXT: begin
                    word_idx_q <= '0;
`ifdef UART_MEM_STREAMER_CHECKSUM_EN
                    acc_q      <= 8'h00;
`endif
                    if (region_q == RG_W'(NUM_REGIONS - 1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        region_q   <= nxt_region_s;
                        state_q    <= S_FETCH;
                        mem_rd_q   <= (field(region_len_i, nxt_region_s) != '0);
                        mem_addr_q <= field(region_base_i, nxt_region_s);
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    wvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd_o   = mem_rd_q;
    assign mem_addr_o = mem_addr_q;
    assign wvalid_o   = wvalid_q;
    assign wdata_o    = wdata_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign region_o   = region_q;

endmodule

// File: doc/uart_mem_streamer.md
Name: uart_mem_streamer

Overview:
- Synthesizable, parametrised successor to the bench-side UART image loader.
- Walks NUM_REGIONS memory regions (for example imem then dram) through a synchronous-read memory port, serialises each DATA_W-bit word into bytes, and pushes them to a byte sink (uart_tx) over a valid/ready handshake.
- Used in simulation tops and on-board as a bootstrap sender, with a programmable start delay and per-region progress reporting.

Parameters:
- DATA_W, 32: memory word width; must be a multiple of 8; BYTES = DATA_W/8.
- ADDR_W, 16: word-address width of the memory port and of the region base/length fields.
- NUM_REGIONS, 2: number of regions streamed, in ascending index order.
- START_DELAY, 400000: idle cycles between accepting start_i and the first memory read.
- MSB_FIRST, 0: 0 sends bits [7:0] first; 1 sends bits [DATA_W-1:DATA_W-8] first.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start pulse; honoured only in IDLE or DONE.
- region_base_i  in  NUM_REGIONS*ADDR_W  base word address of region r, in slice [r*ADDR_W +: ADDR_W].
- region_len_i  in  NUM_REGIONS*ADDR_W  word count of region r; 0 means the region is empty.
- mem_rd_o  out  1  read strobe, one cycle per word.
- mem_addr_o  out  ADDR_W  word address; valid while mem_rd_o is high.
- mem_rdata_i  in  DATA_W  read data, valid exactly one cycle after mem_rd_o.
- wvalid_o  out  1  byte valid.
- wready_i  in  1  sink ready.
- wdata_o  out  8  byte data.
- busy_o  out  1  high in every state except IDLE and DONE.
- done_o  out  1  sticky completion flag.
- region_o  out  max(1,$clog2(NUM_REGIONS))  index of the region being streamed.

Behaviour:
- Reset values: mem_rd_o=0, mem_addr_o=0, wvalid_o=0, wdata_o=0, busy_o=0, done_o=0, region_o=0; state IDLE; all counters 0.
- Reset is honoured in any state. If asserted mid-byte, wvalid_o drops on the next edge and the byte is abandoned.

State machine:
- IDLE/DONE --start_i--> WAIT. Clears done_o, loads the delay counter, sets region=0.
- WAIT: counts START_DELAY cycles, then goes to FETCH. START_DELAY=0 goes to FETCH on the next cycle.
- FETCH:
  - If the current region's length is 0, go to NEXT.
  - Otherwise assert mem_rd_o for one cycle with mem_addr_o = base + word_idx (mod 2^ADDR_W), then go to LOAD.
- LOAD: capture mem_rdata_i into the shift register, byte_idx=0, go to SEND.
- SEND:
  - wvalid_o=1 and wdata_o = current byte. Both stay stable until the cycle where wvalid_o && wready_i.
  - On each accept: byte_idx++. If this was byte BYTES-1, word_idx++ and go to FETCH, or to NEXT when word_idx+1 == length.
  - Handshake rules: the next byte may be presented on the cycle immediately after an accept. wvalid_o never depends combinationally on wready_i.
- NEXT: word_idx=0. If region == NUM_REGIONS-1, go to DONE; otherwise region++ and go to FETCH.
- DONE: done_o=1 and held until the next accepted start_i.

Other rules:
- start_i is ignored while busy_o=1.
- Throughput: BYTES handshakes per word plus 2 overhead cycles (FETCH, LOAD).
- Region inputs are sampled live. They must be held stable while busy_o=1; otherwise behaviour is undefined.

Optional Feature:
- Macro: UART_MEM_STREAMER_CHECKSUM_EN.
- Defined:
  - After the last word of each region, a state CSUM sends one extra byte through the same handshake.
  - The byte is the two's-complement of the 8-bit sum of all data bytes in that region, so that the sum of all bytes including the checksum is 0 mod 256.
  - An empty region sends checksum 0x00.
  - The accumulator clears on entry to each region.
- Undefined: no CSUM state and no accumulator logic; NEXT follows the last word directly.

Test Plan:
- Basic stream: DATA_W=32, START_DELAY=4, regions {base 0, len 2} and {base 0x10, len 1}, memory words 0x44332211, 0x88776655, 0xDDCCBBAA, wready_i=1 -> bytes 11 22 33 44 55 66 77 88 AA BB CC DD in order; done_o rises after the 12th accept; the first mem_rd_o occurs exactly 4 cycles after leaving IDLE.
- Backpressure: wready_i toggled in a random pattern -> wdata_o is stable while valid and unaccepted; no byte is lost or duplicated.
- Empty and wrap cases:
  - Region 0 len=0 -> region 0 sends no bytes; region_o steps to 1.
  - base 0xFFFF, len 2, ADDR_W=16 -> mem_addr_o goes 0xFFFF then 0x0000.
- MSB_FIRST=1 with word 0x44332211 -> bytes 44 33 22 11.
- Reset and start rules:
  - rst_i asserted during SEND byte 2 -> next cycle wvalid_o=0, busy_o=0, done_o=0.
  - A subsequent start_i restarts from region 0, word 0.
  - start_i while busy -> no effect.
- With UART_MEM_STREAMER_CHECKSUM_EN and region bytes 11 22 33 44 -> extra byte 0x56 is sent; an empty region sends 0x00.
